// File: rtl/xswitch_nxn.sv
// N x N crossbar: per-output round-robin arbitration into a per-output FIFO.
// Inputs addressed beyond N_PORTS-1 are consumed immediately and flagged on err_addr.
module xswitch_nxn #(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_W    = $clog2(N_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS*DATA_W-1:0]   data_in,
  input  logic [N_PORTS*ADDR_W-1:0]   addr_in,
  input  logic [N_PORTS-1:0]          valid_in,
  output logic [N_PORTS-1:0]          data_read,
  output logic [N_PORTS*DATA_W-1:0]   data_out,
  output logic [N_PORTS*ADDR_W-1:0]   addr_out,
  output logic [N_PORTS-1:0]          data_rdy,
  input  logic [N_PORTS-1:0]          rcv_rdy,
  output logic [N_PORTS-1:0]          err_addr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]  N_LIM    = (ADDR_W + 1)'(N_PORTS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  in_addr [N_PORTS];
  logic [N_PORTS-1:0] bad_addr;
  logic [N_PORTS-1:0] req     [N_PORTS];
  logic [N_PORTS-1:0] gnt     [N_PORTS];
  logic [ADDR_W-1:0]  gnt_src [N_PORTS];
  logic [ADDR_W-1:0]  rr_q    [N_PORTS];
  logic [ADDR_W-1:0]  rr_d    [N_PORTS];
  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] push;
  logic [N_PORTS-1:0] err_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_in
      assign in_addr[gi]  = addr_in[gi*ADDR_W +: ADDR_W];
      assign bad_addr[gi] = valid_in[gi] && ({1'b0, in_addr[gi]} >= N_LIM);
    end
  endgenerate

  // Per-output cyclic search starting at rr_q[j]; a full FIFO grants nobody.
  always_comb begin : arb
    int                idx;
    logic [ADDR_W-1:0] idx_a;
    logic              found;
    idx   = 0;
    idx_a = '0;
    found = 1'b0;
    for (int j = 0; j < N_PORTS; j++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        req[j][i] = valid_in[i] && (in_addr[i] == ADDR_W'(j));
      end
      gnt[j]     = '0;
      gnt_src[j] = '0;
      rr_d[j]    = rr_q[j];
      found      = 1'b0;
      if (!full[j]) begin
        for (int k = 0; k < N_PORTS; k++) begin
          idx   = (int'(rr_q[j]) + k) % N_PORTS;
          idx_a = ADDR_W'(idx);
          if (!found && req[j][idx_a]) begin
            found          = 1'b1;
            gnt[j][idx_a]  = 1'b1;
            gnt_src[j]     = idx_a;
            rr_d[j]        = ADDR_W'((idx + 1) % N_PORTS);
          end
        end
      end
    end
  end

  always_comb begin
    data_read = bad_addr;
    for (int j = 0; j < N_PORTS; j++) begin
      data_read = data_read | gnt[j];
      push[j]   = reset && (|gnt[j]);
    end
    data_read = data_read & {N_PORTS{reset}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N_PORTS; j++) rr_q[j] <= '0;
      err_q <= '0;
    end else begin
      for (int j = 0; j < N_PORTS; j++) rr_q[j] <= rr_d[j];
      err_q <= bad_addr;
    end
  end

  assign err_addr = err_q;

  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_fifo
      logic [ENT_W-1:0]  mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic              pop;
      logic [DATA_W-1:0] wdata;

      assign pop      = (cnt_q != '0) && rcv_rdy[gi];
      assign full[gi] = (cnt_q == FULL_CNT);
      assign wdata    = data_in[int'(gnt_src[gi])*DATA_W +: DATA_W];

      always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push[gi]) wr_d = wr_q + PTR_W'(1);
        if (pop)      rd_d = rd_q + PTR_W'(1);
        case ({push[gi], pop})
          2'b10:   cnt_d = cnt_q + CNT_W'(1);
          2'b01:   cnt_d = cnt_q - CNT_W'(1);
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          wr_q  <= wr_d;
          rd_q  <= rd_d;
          cnt_q <= cnt_d;
        end
      end

      // Storage needs no reset: the head is masked to zero whenever the count is zero.
      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_q] <= {gnt_src[gi], wdata};
      end

      assign data_rdy[gi]                   = (cnt_q != '0);
      assign data_out[gi*DATA_W +: DATA_W]  = data_rdy[gi] ? mem[rd_q][DATA_W-1:0]     : '0;
      assign addr_out[gi*ADDR_W +: ADDR_W]  = data_rdy[gi] ? mem[rd_q][ENT_W-1:DATA_W] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_xswitch_nxn.sv
// Bench for xswitch_nxn: queue-based reference model checked every cycle, a vector
// table, hand sequences for contention/full/reset, and a 3-port instance for bad addresses.
module tb_xswitch_nxn;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic [7:0]  addr_in;
  logic [3:0]  valid_in;
  logic [3:0]  data_read;
  logic [31:0] data_out;
  logic [7:0]  addr_out;
  logic [3:0]  data_rdy;
  logic [3:0]  rcv_rdy;
  logic [3:0]  err_addr;

  logic [23:0] d3_data_in;
  logic [5:0]  d3_addr_in;
  logic [2:0]  d3_valid;
  logic [2:0]  d3_read;
  logic [23:0] d3_data_out;
  logic [5:0]  d3_addr_out;
  logic [2:0]  d3_rdy;
  logic [2:0]  d3_rcv;
  logic [2:0]  d3_err;

  xswitch_nxn #(.N_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .addr_in(addr_in), .valid_in(valid_in),
    .data_read(data_read), .data_out(data_out), .addr_out(addr_out), .data_rdy(data_rdy),
    .rcv_rdy(rcv_rdy), .err_addr(err_addr)
  );

  xswitch_nxn #(.N_PORTS(3), .DATA_W(8), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .data_in(d3_data_in), .addr_in(d3_addr_in), .valid_in(d3_valid),
    .data_read(d3_read), .data_out(d3_data_out), .addr_out(d3_addr_out), .data_rdy(d3_rdy),
    .rcv_rdy(d3_rcv), .err_addr(d3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue of {src, data} per output plus a round-robin pointer.
  logic [9:0] mq [4][$];
  int         rr_m [4];
  int         win_m [4];
  logic [3:0] exp_rd_m;
  logic [3:0] rd_seen;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] addr;
    logic [3:0] exp_read;
    logic [3:0] exp_rdy;
    logic [7:0] exp_ao;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Winner for output j is the requester with the smallest cyclic distance from rr_m[j].
  task automatic model_predict();
    exp_rd_m = '0;
    for (int j = 0; j < 4; j++) begin
      int bestd;
      win_m[j] = -1;
      bestd    = 99;
      if (mq[j].size() < 4) begin
        for (int i = 0; i < 4; i++) begin
          if (valid_in[i] && int'(addr_in[i*2 +: 2]) == j) begin
            int d;
            d = (i - rr_m[j] + 4) % 4;
            if (d < bestd) begin
              bestd    = d;
              win_m[j] = i;
            end
          end
        end
      end
      if (win_m[j] >= 0) exp_rd_m[win_m[j]] = 1'b1;
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    logic [31:0] e_do;
    logic [7:0]  e_ao;
    logic [3:0]  e_rdy;
    #2;
    e_do  = '0;
    e_ao  = '0;
    e_rdy = '0;
    for (int j = 0; j < 4; j++) begin
      if (mq[j].size() > 0) begin
        e_rdy[j]         = 1'b1;
        e_do[j*8 +: 8]   = mq[j][0][7:0];
        e_ao[j*2 +: 2]   = mq[j][0][9:8];
      end
    end
    check("data_rdy", 64'(data_rdy), 64'(e_rdy));
    check("data_out", 64'(data_out), 64'(e_do));
    check("addr_out", 64'(addr_out), 64'(e_ao));
    check("err_addr", 64'(err_addr), 64'(0));
    model_predict();
    check("data_read", 64'(data_read), 64'(exp_rd_m));
    rd_seen = data_read;
    @(posedge clk);
    for (int j = 0; j < 4; j++)
      if (mq[j].size() > 0 && rcv_rdy[j]) void'(mq[j].pop_front());
    for (int j = 0; j < 4; j++) begin
      if (win_m[j] >= 0) begin
        mq[j].push_back({2'(win_m[j]), data_in[win_m[j]*8 +: 8]});
        rr_m[j] = (win_m[j] + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic model_clear();
    for (int j = 0; j < 4; j++) begin
      mq[j].delete();
      rr_m[j] = 0;
    end
  endtask

  task automatic do_reset();
    valid_in = '0;
    reset    = 1'b0;
    #2;
    check("rst_data_rdy", 64'(data_rdy), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive(input int i, input int a, input logic [7:0] d);
    valid_in[i]        = 1'b1;
    addr_in[i*2 +: 2]  = 2'(a);
    data_in[i*8 +: 8]  = d;
  endtask

  initial begin
    reset      = 1'b0;
    data_in    = '0;
    addr_in    = '0;
    valid_in   = '0;
    rcv_rdy    = '0;
    d3_data_in = '0;
    d3_addr_in = '0;
    d3_valid   = '0;
    d3_rcv     = '0;
    rd_seen    = '0;
    model_clear();

    vecs[0] = '{4'b0010, 8'b00_00_10_00, 4'b0010, 4'b0100, 8'b00_01_00_00};
    vecs[1] = '{4'b1111, 8'b00_01_10_11, 4'b1111, 4'b1111, 8'b00_01_10_11};
    vecs[2] = '{4'b1111, 8'b00_00_00_00, 4'b0001, 4'b0001, 8'b00_00_00_00};
    vecs[3] = '{4'b1010, 8'b00_00_00_00, 4'b0010, 4'b0001, 8'b00_00_00_01};
    vecs[4] = '{4'b1111, 8'b10_10_01_01, 4'b0101, 4'b0110, 8'b00_10_00_00};
    vecs[5] = '{4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 8'b00_00_00_00};

    @(posedge clk);
    #1;
    check("reset_data_read", 64'(data_read), 64'(0));

    // Single-cycle vector table, each from a clean reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      rcv_rdy  = '0;
      data_in  = {8'h44, 8'h33, 8'hA5, 8'h11};
      valid_in = vecs[v].valid;
      addr_in  = vecs[v].addr;
      step();
      check("vec_read", 64'(rd_seen), 64'(vecs[v].exp_read));
      valid_in = '0;
      #1;
      check("vec_rdy", 64'(data_rdy), 64'(vecs[v].exp_rdy));
      check("vec_addr_out", 64'(addr_out), 64'(vecs[v].exp_ao));
      $display("vec %0d valid=%b read=%b rdy=%b", v, vecs[v].valid, rd_seen, data_rdy);
    end

    // Contention on out0 from inputs 0,1,3, two rounds
    do_reset();
    rcv_rdy = 4'hF;
    for (int r = 0; r < 2; r++) begin
      int seq [3];
      seq = '{0, 1, 3};
      drive(0, 0, 8'(8'h10 + r));
      drive(1, 0, 8'(8'h20 + r));
      drive(3, 0, 8'(8'h30 + r));
      for (int c = 0; c < 3; c++) begin
        step();
        check("contention_grant", 64'(rd_seen), 64'(1 << seq[c]));
        $display("contention round %0d cycle %0d read=%b", r, c, rd_seen);
        valid_in = valid_in & ~exp_rd_m;
      end
    end
    step();

    // Full FIFO on out3
    do_reset();
    rcv_rdy = '0;
    for (int k = 1; k <= 5; k++) begin
      drive(0, 3, 8'(k));
      step();
      check("full_accept", 64'(rd_seen[0]), 64'(k <= 4));
      $display("full push word %0d read=%b", k, rd_seen[0]);
      if (exp_rd_m[0]) valid_in[0] = 1'b0;
    end
    rcv_rdy[3] = 1'b1;
    step();
    check("full_blocks_with_pop", 64'(rd_seen[0]), 64'(0));
    rcv_rdy[3] = 1'b0;
    step();
    check("full_accept_after_pop", 64'(rd_seen[0]), 64'(1));
    valid_in = '0;
    rcv_rdy[3] = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      #1;
      check("full_order", 64'(data_out[31:24]), 64'(k));
      $display("drain out3 head=%0h", data_out[31:24]);
      step();
    end
    rcv_rdy = '0;

    // Bad address on the 3-port instance
    do_reset();
    d3_data_in[23:16] = 8'h5A;
    d3_addr_in[5:4]   = 2'd3;
    d3_valid          = 3'b100;
    #2;
    check("bad_read", 64'(d3_read), 64'(3'b100));
    check("bad_err_early", 64'(d3_err), 64'(0));
    @(posedge clk);
    #1;
    d3_valid = '0;
    #1;
    check("bad_err_pulse", 64'(d3_err), 64'(3'b100));
    check("bad_no_rdy", 64'(d3_rdy), 64'(0));
    @(posedge clk);
    #1;
    check("bad_err_end", 64'(d3_err), 64'(0));
    check("bad_no_rdy2", 64'(d3_rdy), 64'(0));
    $display("bad addr err pulse checked");

    // Reset mid-run with out1 holding three words
    do_reset();
    rcv_rdy = '0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 8'(8'h61 + k));
      step();
      valid_in[1] = 1'b0;
    end
    drive(1, 1, 8'h64);
    reset = 1'b0;
    #1;
    check("midrst_rdy", 64'(data_rdy), 64'(0));
    check("midrst_read", 64'(data_read), 64'(0));
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1, 1, 8'h77);
    step();
    valid_in = '0;
    #1;
    check("midrst_head", 64'(data_out[15:8]), 64'(8'h77));
    check("midrst_src", 64'(addr_out[3:2]), 64'(1));
    check("midrst_rdy_after", 64'(data_rdy), 64'(4'b0010));
    $display("reset mid-run head=%0h rdy=%b", data_out[15:8], data_rdy);

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!valid_in[i] && $urandom_range(0, 2) != 0)
          drive(i, $urandom_range(0, 3), 8'($urandom));
      end
      rcv_rdy = ((c % 100) < 40) ? 4'($urandom & $urandom) : 4'($urandom);
      step();
      valid_in = valid_in & ~exp_rd_m;
    end
    $display("random phase done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
